turbo_stream_receiver: RTL and testbench

- Receive end of the turbo encoder output stream: consumes the serial xk/zk/zkp triplets qualified by look_now, plus the registered length flag.
- Frames each code block as K data cycles followed by 4 trellis-tail cycles.
- Re-runs constituent encoder 1 on the received systematic bits to check zk parity and the encoder-1 tail bits.
- Passes systematic bits downstream and reports per-block status. Sits between the encoder output and the rate-matching / loopback-test logic.

---
 rtl/turbo_stream_receiver.sv | 168 ++++++++++++++++
 tb/tb_turbo_stream_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/turbo_stream_receiver.sv
// turbo_stream_receiver
// Receive side of the turbo encoder output stream. Frames each code block as
// K data cycles plus 4 trellis-tail cycles, re-runs constituent encoder 1 on
// the received systematic bits to check zk parity and the encoder-1 tail, and
// forwards systematic bits downstream with per-block status.
module turbo_stream_receiver #(
    parameter int K_SHORT = 1056,
    parameter int K_LONG  = 6144,
    parameter int CNT_W   = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             look_now,
    input  logic             length_out,
    input  logic             xk,
    input  logic             zk,
    input  logic             zkp,
    output logic             sys_bit,
    output logic             sys_valid,
    output logic             block_done,
    output logic             parity_err,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [11:0]      tail_bits,
    output logic             framing_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(K_SHORT - 1);
    localparam logic [CNT_W-1:0] LAST_LONG  = CNT_W'(K_LONG - 1);

    state_t           state;
    logic             len_q;     // length flag latched on the first data cycle
    logic [CNT_W-1:0] pos;       // data index in DATA, tail index in TAIL
    logic             s1, s2, s3;
    logic [CNT_W-1:0] run_cnt;   // mismatches accumulated in the current block
    logic [8:0]       tail_cap;  // tail cycles 0..2; cycle 3 goes straight out

    logic             data_cyc, tail_cyc, abort, len_sel, last_data, tail_last;
    logic [CNT_W-1:0] idx, cnt_base, cnt_next;
    logic             a, exp_z;
    logic             x0, z0, x1, z1, x2, z2;
    logic [1:0]       inc;
    logic [CNT_W:0]   sum;

    // Decode the current stream cycle and evaluate the encoder-1 model.
    // NOTE: every signal gets a default at the top so no path can infer a latch.
    always_comb begin
        data_cyc  = look_now && (state == IDLE || state == DATA);
        tail_cyc  = look_now && (state == TAIL);
        abort     = !look_now && (state != IDLE);
        // The first data cycle arrives while still in IDLE, so it uses the
        // live length flag and index 0.
        len_sel   = (state == IDLE) ? length_out : len_q;
        idx       = (state == IDLE) ? '0 : pos;
        last_data = (idx == (len_sel ? LAST_LONG : LAST_SHORT));
        tail_last = tail_cyc && (pos == CNT_W'(3));

        a     = xk ^ s2 ^ s3;
        exp_z = a ^ s1 ^ s3;

        // The three termination steps are unrolled from the state left by the
        // last data bit, so the model registers hold still during TAIL.
        x0 = s2 ^ s3;
        z0 = s1 ^ s3;
        x1 = s1 ^ s2;
        z1 = s2;
        x2 = s1;
        z2 = s1;

        inc = 2'd0;
        if (data_cyc) begin
            inc = {1'b0, zk != exp_z};
        end else if (tail_cyc && pos == CNT_W'(0)) begin
            inc = 2'(xk != x0) + 2'(zk != z0) + 2'(zkp != x1);
        end else if (tail_cyc && pos == CNT_W'(1)) begin
            inc = 2'(xk != z1) + 2'(zk != x2) + 2'(zkp != z2);
        end

        cnt_base = (state == IDLE) ? '0 : run_cnt;
        sum      = {1'b0, cnt_base} + (CNT_W + 1)'(inc);
        cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    // Framing FSM, encoder-1 model, mismatch accounting and registered outputs.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= 1'b0;
            pos          <= '0;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            run_cnt      <= '0;
            tail_cap     <= '0;
            sys_bit      <= 1'b0;
            sys_valid    <= 1'b0;
            block_done   <= 1'b0;
            parity_err   <= 1'b0;
            mismatch_cnt <= '0;
            tail_bits    <= '0;
            framing_err  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            block_done <= 1'b0;
            sys_valid  <= data_cyc;
            sys_bit    <= data_cyc & xk;

            if (abort) begin
                // Stream dropped mid-block: discard it, keep previous status.
                framing_err <= 1'b1;
                state       <= IDLE;
                busy        <= 1'b0;
                pos         <= '0;
                run_cnt     <= '0;
                s1          <= 1'b0;
                s2          <= 1'b0;
                s3          <= 1'b0;
            end else if (data_cyc) begin
                s1      <= a;
                s2      <= s1;
                s3      <= s2;
                run_cnt <= cnt_next;
                busy    <= 1'b1;
                if (state == IDLE) begin
                    len_q <= length_out;
                end
                if (last_data) begin
                    state <= TAIL;
                    pos   <= '0;
                end else begin
                    state <= DATA;
                    pos   <= idx + CNT_W'(1);
                end
            end else if (tail_cyc) begin
                run_cnt <= cnt_next;
                case (pos[1:0])
                    2'd0:    tail_cap[2:0] <= {zkp, zk, xk};
                    2'd1:    tail_cap[5:3] <= {zkp, zk, xk};
                    2'd2:    tail_cap[8:6] <= {zkp, zk, xk};
                    default: ;
                endcase
                if (tail_last) begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    pos          <= '0;
                    run_cnt      <= '0;
                    s1           <= 1'b0;
                    s2           <= 1'b0;
                    s3           <= 1'b0;
                    block_done   <= 1'b1;
                    mismatch_cnt <= cnt_next;
                    parity_err   <= (cnt_next != '0);
                    tail_bits    <= {zkp, zk, xk, tail_cap};
                end else begin
                    pos <= pos + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_turbo_stream_receiver.sv
// Self-checking bench for turbo_stream_receiver with K_SHORT=4, K_LONG=6.
// Expected systematic bits and block status are queued as blocks are driven
// and compared when sys_valid / block_done appear.
module tb_turbo_stream_receiver;

    localparam int KS = 4;
    localparam int KL = 6;
    localparam int CW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          look_now, length_out, xk, zk, zkp;
    logic          sys_bit, sys_valid, block_done, parity_err, framing_err, busy;
    logic [CW-1:0] mismatch_cnt;
    logic [11:0]   tail_bits;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          perr;
        logic [11:0]   tail;
    } status_t;

    status_t stat_q[$];
    logic    sys_q[$];
    int      done_times[$];
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_fail = 0;
    logic    exp_b;
    status_t exp_s;
    int      s1_start, s2_start, s_tmp;

    turbo_stream_receiver #(.K_SHORT(KS), .K_LONG(KL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .look_now(look_now), .length_out(length_out),
        .xk(xk), .zk(zk), .zkp(zkp), .sys_bit(sys_bit), .sys_valid(sys_valid),
        .block_done(block_done), .parity_err(parity_err),
        .mismatch_cnt(mismatch_cnt), .tail_bits(tail_bits),
        .framing_err(framing_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic status_t mk(input int cnt, input logic perr, input logic [11:0] tail);
        mk = '{cnt: CW'(cnt), perr: perr, tail: tail};
    endfunction

    // Scoreboard: pop expectations as the DUT produces them.
    always @(negedge clk) begin
        if (!rst) begin
            if (sys_valid) begin
                if (sys_q.size() == 0) begin
                    check("sys_valid_unexpected", 32'(sys_valid), 32'd0);
                end else begin
                    exp_b = sys_q.pop_front();
                    check("sys_bit", 32'(sys_bit), 32'(exp_b));
                end
            end
            if (block_done) begin
                done_times.push_back(cyc);
                if (stat_q.size() == 0) begin
                    check("block_done_unexpected", 32'(block_done), 32'd0);
                end else begin
                    exp_s = stat_q.pop_front();
                    check("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_s.cnt));
                    check("parity_err", 32'(parity_err), 32'(exp_s.perr));
                    check("tail_bits", 32'(tail_bits), 32'(exp_s.tail));
                end
            end
        end
    end

    task automatic step(input logic lv, input logic ln, input logic x, input logic z, input logic p);
        look_now   = lv;
        length_out = ln;
        xk         = x;
        zk         = z;
        zkp        = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    // Drives one full block; length_out and data-cycle zkp are randomised
    // wherever the receiver must ignore them.
    task automatic send_block(input logic len, input logic [5:0] xv, input logic [5:0] zv,
                              input logic [11:0] tv, input status_t st, output int start);
        int k;
        k = len ? KL : KS;
        start = 0;
        stat_q.push_back(st);
        for (int i = 0; i < k; i++) begin
            sys_q.push_back(xv[i]);
            step(1'b1, (i == 0) ? len : 1'($urandom), xv[i], zv[i], 1'($urandom));
            if (i == 0) start = cyc;
        end
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'($urandom), tv[3*t], tv[3*t+1], tv[3*t+2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        look_now = 1'b0; length_out = 1'b0; xk = 1'b0; zk = 1'b0; zkp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {sys_bit, sys_valid, block_done, parity_err, mismatch_cnt,
                                tail_bits, framing_err, busy}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Async reset in the middle of DATA.
        sys_q.push_back(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sys_q.push_back(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("busy_mid_block", 32'(busy), 32'd1);
        @(negedge clk);
        look_now = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_outputs", {sys_bit, sys_valid, block_done, parity_err, mismatch_cnt,
                                    tail_bits, framing_err, busy}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("sys_q_after_rst", 32'(sys_q.size()), 32'd0);

        // All-zero short block.
        send_block(1'b0, 6'b0, 6'b0, 12'h000, mk(0, 1'b0, 12'h000), s_tmp);
        idle(2);
        check("short_done_latency", 32'(done_times[done_times.size()-1] - s_tmp), 32'd7);

        // Clean short block with non-trivial parity and tail.
        send_block(1'b0, 6'b000001, 6'b001111, 12'h03B, mk(0, 1'b0, 12'h03B), s_tmp);
        idle(1);

        // Data-cycle-2 zk and tail-cycle-1 xk corrupted.
        send_block(1'b0, 6'b000001, 6'b001011, 12'h033, mk(2, 1'b1, 12'h033), s_tmp);
        idle(1);
        check("parity_err_held", 32'(parity_err), 32'd1);

        // Long all-zero block, then zero-gap short block.
        send_block(1'b1, 6'b0, 6'b0, 12'h000, mk(0, 1'b0, 12'h000), s1_start);
        send_block(1'b0, 6'b000001, 6'b001111, 12'h03B, mk(0, 1'b0, 12'h03B), s2_start);
        idle(2);
        check("b2b_first_done", 32'(done_times[done_times.size()-2] - s1_start), 32'd9);
        check("b2b_spacing", 32'(done_times[done_times.size()-1] - done_times[done_times.size()-2]), 32'd8);
        check("b2b_second_start", 32'(s2_start - s1_start), 32'd10);

        // look_now dropped at data index 2.
        sys_q.push_back(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        sys_q.push_back(1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("framing_busy", 32'(busy), 32'd0);
        check("framing_err_set", 32'(framing_err), 32'd1);
        idle(1);
        check("framing_tail_held", 32'(tail_bits), 32'h03B);
        check("framing_cnt_held", 32'(mismatch_cnt), 32'd0);
        send_block(1'b0, 6'b0, 6'b0, 12'h000, mk(0, 1'b0, 12'h000), s_tmp);
        idle(2);
        check("framing_err_sticky", 32'(framing_err), 32'd1);

        check("done_count", 32'(done_times.size()), 32'd6);
        check("sys_q_drained", 32'(sys_q.size()), 32'd0);
        check("stat_q_drained", 32'(stat_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
